// File: rtl/fact_unit_pkg.sv
// Shared definitions for the factorial engine: FSM state encoding and default widths.
package fact_unit_pkg;

  localparam int unsigned SIZE_DEF  = 8;
  localparam int unsigned PSIZE_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MULT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fact_unit_if.sv
// Request/result bundle of the factorial engine: start/ready handshake, operand, result flags.
interface fact_unit_if
  import fact_unit_pkg::*;
#(
  parameter int unsigned SIZE  = SIZE_DEF,
  parameter int unsigned PSIZE = PSIZE_DEF
);

  logic             start_;
  logic [SIZE-1:0]  n_;
  logic             ready_;
  logic             done_;
  logic [PSIZE-1:0] result_;
  logic             ovf_;

  modport master (
    output start_, n_,
    input  ready_, done_, result_, ovf_
  );

  modport slave (
    input  start_, n_,
    output ready_, done_, result_, ovf_
  );

endinterface

// File: rtl/fact_unit_cnt.sv
// Loadable up-counter feeding the factorial multiplier; load has priority over enable.
module cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_,
  input  logic             rst_n_,
  input  logic             load_cnt_,
  input  logic             en_,
  input  logic [WIDTH-1:0] d_,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk_) begin
    if (!rst_n_) begin
      q <= '0;
    end else if (load_cnt_) begin
      q <= d_;
    end else if (en_) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fact_unit.sv
// Iterative factorial engine: multiplies a product register by an up-counter until it passes n.
module fact_unit
  import fact_unit_pkg::*;
#(
  parameter int unsigned SIZE  = SIZE_DEF,
  parameter int unsigned PSIZE = PSIZE_DEF
) (
  input  logic      clk_,
  input  logic      rst_n_,
  fact_unit_if.slave bus
);

  localparam int unsigned FW = PSIZE + SIZE + 1;

  state_t           state;
  logic [SIZE-1:0]  n_reg;
  logic [SIZE:0]    q;
  logic [PSIZE-1:0] prod;
  logic             ovf;
  logic             ready_r;
  logic             done_r;
  logic             load_cnt;
  logic             en;
  logic             finished;
  logic [FW-1:0]    full;

  always_comb begin
    finished = (q > {1'b0, n_reg});
    load_cnt = (state == LOAD);
    en       = (state == MULT) && !finished;
    full     = {{(SIZE + 1){1'b0}}, prod} * {{PSIZE{1'b0}}, q};
  end

  // One bit wider than the operand so q can reach n+1 when n is all ones.
  cnt #(
    .WIDTH(SIZE + 1)
  ) u_cnt (
    .clk_     (clk_),
    .rst_n_   (rst_n_),
    .load_cnt_(load_cnt),
    .en_      (en),
    .d_       ((SIZE + 1)'(1)),
    .q        (q)
  );

  // ready/done are registered alongside the state so they reflect it exactly.
  always_ff @(posedge clk_) begin
    if (!rst_n_) begin
      state   <= IDLE;
      n_reg   <= '0;
      prod    <= '0;
      ovf     <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_) begin
            n_reg   <= bus.n_;
            ready_r <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          prod  <= PSIZE'(1);
          ovf   <= 1'b0;
          state <= MULT;
        end
        MULT: begin
          if (finished) begin
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            prod <= full[PSIZE-1:0];
            ovf  <= ovf | (|full[FW-1:PSIZE]);
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_  = ready_r;
  assign bus.done_   = done_r;
  assign bus.result_ = prod;
  assign bus.ovf_    = ovf;

endmodule

// File: tb/tb_fact_unit.sv
// Self-checking bench for fact_unit: scoreboard of expected results checked on each done pulse.
module tb_fact_unit;

  typedef struct {
    int unsigned n;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  fact_unit_if #(.SIZE(8), .PSIZE(32)) bus ();

  fact_unit #(.SIZE(8), .PSIZE(32)) dut (
    .clk_  (clk),
    .rst_n_(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int unsigned n);
    exp_t e;
    logic [63:0] p;
    e.n   = n;
    e.res = 32'd1;
    e.ovf = 1'b0;
    for (int unsigned k = 1; k <= n; k++) begin
      p = {32'd0, e.res} * 64'(k);
      if (p[63:32] != 32'd0) e.ovf = 1'b1;
      e.res = p[31:0];
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending request.
  always @(negedge clk) begin
    if (rst_n && bus.done_ === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done result=%0d ovf=%0b", bus.result_, bus.ovf_);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.result_ !== e.res || bus.ovf_ !== e.ovf) begin
          errors++;
          $display("FAIL result n=%0d got=%0d/%0b exp=%0d/%0b",
                   e.n, bus.result_, bus.ovf_, e.res, e.ovf);
        end
      end
    end
  end

  task automatic wait_ready();
    int unsigned i = 0;
    while (bus.ready_ !== 1'b1 && i < 600) begin
      @(posedge clk); #1;
      i++;
    end
    checks++;
    if (bus.ready_ !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got=%b exp=1", bus.ready_);
    end
  endtask

  task automatic wait_done(input int unsigned start_cyc, input int unsigned n);
    int unsigned cyc = start_cyc;
    while (bus.done_ !== 1'b1 && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != n + 3) begin
      errors++;
      $display("FAIL latency n=%0d got=%0d exp=%0d", n, cyc, n + 3);
    end
  endtask

  task automatic run_op(input int unsigned n, input logic [31:0] r, input logic o);
    wait_ready();
    bus.n_     = 8'(n);
    bus.start_ = 1'b1;
    sb.push_back('{n: n, res: r, ovf: o});
    @(posedge clk); #1;
    bus.start_ = 1'b0;
    checks++;
    if (bus.ready_ !== 1'b0) begin
      errors++;
      $display("FAIL accept n=%0d ready got=%b exp=0", n, bus.ready_);
    end
    wait_done(1, n);
    @(posedge clk); #1;
    checks++;
    if (bus.done_ !== 1'b0 || bus.ready_ !== 1'b1) begin
      errors++;
      $display("FAIL after_done n=%0d done/ready got=%b%b exp=01", n, bus.done_, bus.ready_);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.start_ = 1'b0;
    bus.n_     = '0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.ready_ !== 1'b1 || bus.done_ !== 1'b0 || bus.result_ !== 32'd0 || bus.ovf_ !== 1'b0) begin
      errors++;
      $display("FAIL reset ready/done/result/ovf got=%b/%b/%0d/%b exp=1/0/0/0",
               bus.ready_, bus.done_, bus.result_, bus.ovf_);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_op(5, 32'd120, 1'b0);
    run_op(0, 32'd1, 1'b0);
    run_op(1, 32'd1, 1'b0);
  endtask

  task automatic test_overflow();
    exp_t e;
    run_op(12, 32'd479001600, 1'b0);
    run_op(13, 32'd1932053504, 1'b1);
    e = model(255);
    run_op(255, e.res, e.ovf);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e = model($urandom_range(2, 20));
      run_op(e.n, e.res, e.ovf);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    wait_ready();
    bus.n_     = 8'd4;
    bus.start_ = 1'b1;
    sb.push_back('{n: 4, res: 32'd24, ovf: 1'b0});
    @(posedge clk); #1;
    bus.start_ = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.n_     = 8'd9;
    bus.start_ = 1'b1;
    wait_done(4, 4);
    bus.n_ = 8'd6;
    e = model(6);
    sb.push_back(e);
    @(posedge clk); #1;
    checks++;
    if (bus.ready_ !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle ready got=%b exp=1", bus.ready_);
    end
    @(posedge clk); #1;
    bus.start_ = 1'b0;
    checks++;
    if (bus.ready_ !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept ready got=%b exp=0", bus.ready_);
    end
    wait_done(1, 6);
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int unsigned seen = 0;
    wait_ready();
    bus.n_     = 8'd10;
    bus.start_ = 1'b1;
    @(posedge clk); #1;
    bus.start_ = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (bus.ready_ !== 1'b1 || bus.done_ !== 1'b0 || bus.result_ !== 32'd0 || bus.ovf_ !== 1'b0) begin
      errors++;
      $display("FAIL abort ready/done/result/ovf got=%b/%b/%0d/%b exp=1/0/0/0",
               bus.ready_, bus.done_, bus.result_, bus.ovf_);
    end
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done_ === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d exp=0", seen);
    end
    run_op(3, 32'd6, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_random();
    test_back_to_back();
    test_abort();
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
